// File: rtl/myproject_dense_pkg.sv
// Shared widths, counter sizing and the shift/saturate helper for the dense-layer stages.
package myproject_dense_pkg;

  localparam int DEF_PROD_WIDTH = 39;
  localparam int DEF_N_IN       = 16;
  localparam int DEF_BIAS_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 48;
  localparam int DEF_OUT_SHIFT  = 10;
  localparam int DEF_OUT_WIDTH  = 16;

  // Widest accumulator the helper can take; every stage sign-extends into it.
  localparam int SAT_W = 64;

  // Beat counter width for n products per neuron (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_N_IN);

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] data;
  } sat_res_t;

  // Arithmetic right shift (floor) followed by saturation to a signed width-bit range.
  // The returned data is sign-extended to SAT_W bits.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int shift, input int width);
    logic signed [SAT_W-1:0] t;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t r;
    t  = acc >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (t > hi) begin
      r.ovf  = 1'b1;
      r.data = hi;
    end else if (t < lo) begin
      r.ovf  = 1'b1;
      r.data = lo;
    end else begin
      r.ovf  = 1'b0;
      r.data = t;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_dense_sat_shift.sv
// Combinational rescale-and-saturate of a signed accumulator into a narrower signed word.
module myproject_dense_sat_shift
  import myproject_dense_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_ACC_WIDTH,
  parameter int SHIFT     = DEF_OUT_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 ovf
);

  generate
    if (IN_WIDTH >= SAT_W || OUT_WIDTH >= SAT_W) begin : g_bad_width
      $error("myproject_dense_sat_shift: widths must be below SAT_W");
    end
  endgenerate

  logic [SAT_W-1:0]           din_ext;
  logic [SAT_W-OUT_WIDTH-1:0] sat_unused;
  sat_res_t                   sat_r;

  assign din_ext[IN_WIDTH-1:0] = din;

  // Replicate the sign bit up to the helper's fixed width.
  genvar gi;
  generate
    for (gi = IN_WIDTH; gi < SAT_W; gi++) begin : g_sext
      assign din_ext[gi] = din[IN_WIDTH-1];
    end
  endgenerate

  assign sat_r      = sat_shift(din_ext, SHIFT, OUT_WIDTH);
  assign ovf        = sat_r.ovf;
  assign dout       = sat_r.data[OUT_WIDTH-1:0];
  // Upper bits are only the sign extension of dout once saturated.
  assign sat_unused = sat_r.data[SAT_W-1:OUT_WIDTH];

endmodule

// File: rtl/myproject_dense_acc_39s.sv
// Dense-layer accumulator: sums N_IN signed products onto a bias per neuron and emits
// one rescaled, saturated word per neuron through a single-entry valid/ready register.
module myproject_dense_acc_39s
  import myproject_dense_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int N_IN       = DEF_N_IN,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_dat,
  input  logic                  prod_vld,
  output logic                  prod_rdy,
  input  logic [BIAS_WIDTH-1:0] bias_dat,
  output logic [OUT_WIDTH-1:0]  res_dat,
  output logic                  res_ovf,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(N_IN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  // The accumulator is sized so a full group can never overflow it.
  generate
    if (N_IN < 2) begin : g_bad_n
      $error("myproject_dense_acc_39s: N_IN must be at least 2");
    end
    if (ACC_WIDTH < PROD_WIDTH + $clog2(N_IN) + 1) begin : g_bad_acc
      $error("myproject_dense_acc_39s: ACC_WIDTH too small for PROD_WIDTH and N_IN");
    end
    if (BIAS_WIDTH >= ACC_WIDTH || PROD_WIDTH >= ACC_WIDTH) begin : g_bad_bias
      $error("myproject_dense_acc_39s: bias and product must be narrower than ACC_WIDTH");
    end
  endgenerate

  logic [CNT_W-1:0]     cnt_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic                 res_vld_reg;
  logic [OUT_WIDTH-1:0] res_dat_reg;
  logic                 res_ovf_reg;

  logic                 last_beat;
  logic                 accept;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] bias_ext;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [OUT_WIDTH-1:0] sat_dat;
  logic                 sat_ovf;

  assign last_beat = (cnt_reg == LAST_CNT);
  // Only the closing beat needs room in the output register; res_rdy frees it same-cycle.
  assign prod_rdy  = ~last_beat | ~res_vld_reg | res_rdy;
  assign accept    = prod_vld & prod_rdy;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_dat[PROD_WIDTH-1]}}, prod_dat};
  assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias_dat[BIAS_WIDTH-1]}}, bias_dat};
  // First beat of a group restarts from the bias instead of the running sum.
  assign acc_base = (cnt_reg == '0) ? bias_ext : acc_reg;
  assign acc_next = acc_base + prod_ext;

  myproject_dense_sat_shift #(
    .IN_WIDTH (ACC_WIDTH),
    .SHIFT    (OUT_SHIFT),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_sat (
    .din (acc_next),
    .dout(sat_dat),
    .ovf (sat_ovf)
  );

  // Beat counter, running sum and the single-entry result register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      res_vld_reg <= 1'b0;
      res_dat_reg <= '0;
      res_ovf_reg <= 1'b0;
    end else begin
      if (accept) begin
        acc_reg <= acc_next;
        cnt_reg <= last_beat ? '0 : cnt_reg + CNT_W'(1);
      end
      if (accept && last_beat) begin
        res_vld_reg <= 1'b1;
        res_dat_reg <= sat_dat;
        res_ovf_reg <= sat_ovf;
      end else if (res_rdy) begin
        res_vld_reg <= 1'b0;
      end
    end
  end

  assign res_vld = res_vld_reg;
  assign res_dat = res_dat_reg;
  assign res_ovf = res_ovf_reg;
  assign busy    = (cnt_reg != '0);

endmodule

// File: tb/tb_myproject_dense_acc_39s.sv
// Self-checking bench for myproject_dense_acc_39s with N_IN=4: directed groups plus
// randomized traffic against a group-sum reference model.
module tb_myproject_dense_acc_39s;

  localparam int N = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [38:0] prod_dat = '0;
  logic        prod_vld = 1'b0;
  logic        prod_rdy;
  logic [15:0] bias_dat = '0;
  logic [15:0] res_dat;
  logic        res_ovf;
  logic        res_vld;
  logic        res_rdy = 1'b0;
  logic        busy;

  myproject_dense_acc_39s #(
    .PROD_WIDTH(39), .N_IN(N), .BIAS_WIDTH(16),
    .ACC_WIDTH(48), .OUT_SHIFT(10), .OUT_WIDTH(16)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .prod_dat(prod_dat),
    .prod_vld(prod_vld),
    .prod_rdy(prod_rdy),
    .bias_dat(bias_dat),
    .res_dat (res_dat),
    .res_ovf (res_ovf),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .busy    (busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference model: results produced but not yet consumed, plus the open group.
  longint qd[$];
  bit     qo[$];
  int     mcnt;
  longint msum;
  int     n_groups;
  int     n_err;
  int     n_chk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_result(input longint s);
    longint t;
    t = s >>> 10;
    if (t > 32767) begin
      qd.push_back(32767);
      qo.push_back(1'b1);
    end else if (t < -32768) begin
      qd.push_back(-32768);
      qo.push_back(1'b1);
    end else begin
      qd.push_back(t);
      qo.push_back(1'b0);
    end
    n_groups++;
  endfunction

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cycle(input bit v, input longint p, input longint b, input bit rr,
                       output bit accepted);
    bit hs;
    @(negedge ap_clk);
    prod_vld = v;
    prod_dat = p[38:0];
    bias_dat = b[15:0];
    res_rdy  = rr;
    #1;
    chk("res_vld", res_vld, qd.size() != 0);
    if (qd.size() != 0) begin
      chk("res_dat", $signed(res_dat), qd[0]);
      chk("res_ovf", res_ovf, qo[0]);
    end
    chk("busy", busy, mcnt != 0);
    chk("prod_rdy", prod_rdy, (mcnt != N - 1) || (qd.size() == 0) || rr);
    hs       = res_vld && rr;
    accepted = v && prod_rdy;
    if (hs && qd.size() != 0) begin
      $display("result dat=%0d ovf=%0d", $signed(res_dat), res_ovf);
      void'(qd.pop_front());
      void'(qo.pop_front());
    end
    if (accepted) begin
      if (mcnt == 0) msum = b;
      msum += p;
      mcnt++;
      if (mcnt == N) begin
        push_result(msum);
        mcnt = 0;
      end
    end
  endtask

  task automatic send(input longint b, input longint p, input bit rr);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 20 && !a; k++) cycle(1'b1, p, b, rr, a);
    if (!a) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst   = 1'b1;
    prod_vld = 1'b0;
    res_rdy  = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    qd.delete();
    qo.delete();
    mcnt = 0;
    msum = 0;
    #1;
    chk("rst_res_vld", res_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_dat", res_dat, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_prod_rdy", prod_rdy, 1);
  endtask

  function automatic longint rand_prod();
    longint r;
    case ($urandom_range(0, 2))
      0: r = longint'($urandom_range(0, 65535)) - 32768;
      1: r = longint'($urandom_range(0, (1 << 26) - 1)) - (1 << 25);
      default: begin
        r = {$urandom, $urandom};
        r = (r <<< 25) >>> 25;
      end
    endcase
    return r;
  endfunction

  initial begin
    bit a;
    longint p1 [4];
    n_err = 0; n_chk = 0; mcnt = 0; msum = 0; n_groups = 0;
    p1[0] = 1024; p1[1] = 2048; p1[2] = 3072; p1[3] = 4096;
    repeat (2) @(negedge ap_clk);
    do_reset();

    // 1: 10240 / 1024 = 10, consumed immediately
    for (int i = 0; i < 4; i++) send(0, p1[i], 1'b1);
    cycle(1'b0, 0, 0, 1'b1, a);
    cycle(1'b0, 0, 0, 1'b1, a);

    // 2: bias shifts the sum; -1 floors to -1
    for (int i = 0; i < 4; i++) send(-512, 512, 1'b1);
    send(0, -1, 1'b1);
    for (int i = 0; i < 3; i++) send(0, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, a);

    // 3: positive then negative saturation
    for (int i = 0; i < 4; i++) send(0, longint'(1) <<< 37, 1'b1);
    for (int i = 0; i < 4; i++) send(0, -(longint'(1) <<< 38), 1'b1);
    cycle(1'b0, 0, 0, 1'b1, a);
    cycle(1'b0, 0, 0, 1'b1, a);

    // 4: back-pressure only on the closing beat
    for (int i = 0; i < 4; i++) send(0, p1[i], 1'b0);
    for (int i = 0; i < 3; i++) send(0, 1024, 1'b0);
    cycle(1'b1, 1024, 0, 1'b0, a);
    chk("stall_beat4_a", a, 0);
    cycle(1'b1, 1024, 0, 1'b0, a);
    chk("stall_beat4_b", a, 0);
    cycle(1'b1, 1024, 0, 1'b1, a);
    chk("release_beat4", a, 1);
    cycle(1'b0, 0, 0, 1'b1, a);
    cycle(1'b0, 0, 0, 1'b1, a);

    // 5: random gaps and back-pressure over 100 groups
    begin
      int target;
      target = n_groups + 100;
      for (int c = 0; c < 6000 && n_groups < target; c++)
        cycle($urandom_range(0, 1) == 1, rand_prod(),
              longint'($urandom_range(0, 65535)) - 32768,
              $urandom_range(0, 1) == 1, a);
      chk("rand_groups_done", n_groups >= target, 1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b1, a);
    end

    // 6: reset discards a pending result and a partial group
    for (int i = 0; i < 4; i++) send(0, 1024, 1'b0);
    send(0, 1024, 1'b0);
    send(0, 1024, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 1024, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, a);
    cycle(1'b0, 0, 0, 1'b1, a);
    chk("final_queue_empty", qd.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
